// File: rtl/ab_debounce.sv
// ab_debounce: two-channel input conditioner. Each raw asynchronous input is
// brought into the clk domain by a two-flop synchronizer, then filtered by a
// four-state debounce FSM with a down-counter. Produces clean levels plus
// registered one-cycle rise/fall ticks per channel. Channels are independent.
module ab_debounce #(
  parameter int DB_CYCLES = 8,
  parameter int CW        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  // State encoding chosen so bit 1 is the debounced level (Moore decode).
  localparam logic [1:0] ST_ZERO  = 2'b00;
  localparam logic [1:0] ST_WAIT1 = 2'b01;
  localparam logic [1:0] ST_ONE   = 2'b11;
  localparam logic [1:0] ST_WAIT0 = 2'b10;

  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  // Channel 0 is A, channel 1 is B.
  logic [1:0]         raw_s;
  logic [1:0]         s1_q;
  logic [1:0]         s2_q;
  logic [1:0][1:0]    state_q;
  logic [1:0][1:0]    state_d;
  logic [1:0][CW-1:0] cnt_q;
  logic [1:0][CW-1:0] cnt_d;
  logic [1:0]         rise_q;
  logic [1:0]         rise_d;
  logic [1:0]         fall_q;
  logic [1:0]         fall_d;

  assign raw_s = {b_raw, a_raw};

  // Two-flop synchronizer for both raw inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= raw_s;
      s2_q <= s1_q;
    end
  end

  // Debounce next-state logic; a bounce during WAIT discards all progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 2'b00;
    fall_d  = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      case (state_q[ch])
        ST_ZERO: begin
          if (s2_q[ch]) begin
            state_d[ch] = ST_WAIT1;
            cnt_d[ch]   = CNT_LOAD;
          end else begin
            state_d[ch] = ST_ZERO;
          end
        end
        ST_WAIT1: begin
          if (!s2_q[ch]) begin
            state_d[ch] = ST_ZERO;
          end else if (cnt_q[ch] == CNT_ZERO) begin
            state_d[ch] = ST_ONE;
            rise_d[ch]  = 1'b1;
          end else begin
            cnt_d[ch]   = cnt_q[ch] - CNT_ONE;
          end
        end
        ST_ONE: begin
          if (!s2_q[ch]) begin
            state_d[ch] = ST_WAIT0;
            cnt_d[ch]   = CNT_LOAD;
          end else begin
            state_d[ch] = ST_ONE;
          end
        end
        ST_WAIT0: begin
          if (s2_q[ch]) begin
            state_d[ch] = ST_ONE;
          end else if (cnt_q[ch] == CNT_ZERO) begin
            state_d[ch] = ST_ZERO;
            fall_d[ch]  = 1'b1;
          end else begin
            cnt_d[ch]   = cnt_q[ch] - CNT_ONE;
          end
        end
        default: begin
          state_d[ch] = ST_ZERO;
        end
      endcase
    end
  end

  // State, counter and tick registers; ticks live for exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= {ST_ZERO, ST_ZERO};
      cnt_q   <= {CNT_ZERO, CNT_ZERO};
      rise_q  <= 2'b00;
      fall_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign a      = state_q[0][1];
  assign b      = state_q[1][1];
  assign a_rise = rise_q[0];
  assign a_fall = fall_q[0];
  assign b_rise = rise_q[1];
  assign b_fall = fall_q[1];

endmodule

// File: tb/tb_ab_debounce.sv
// Bench for ab_debounce: table-driven pulse vectors plus hand-written
// sequences, with expected ticks held in a cycle-stamped scoreboard queue.
module tb_ab_debounce;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    bit ch;    // 0 = A, 1 = B
    bit rise;  // 1 = rise tick, 0 = fall tick
  } ev_t;
  ev_t exp_q[$];

  // Pulse vector: raw high for *_len cycles from the start; *_re/*_fe are the
  // expected rise/fall tick edges relative to the start (0 = no tick).
  typedef struct {
    int a_len; int b_len;
    int a_re;  int a_fe;
    int b_re;  int b_fe;
  } vec_t;
  vec_t vecs[7];

  ab_debounce #(.DB_CYCLES(8), .CW(4)) dut (
    .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
    .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
    end
  endtask

  task automatic push(input int c, input bit ch, input bit rise);
    ev_t e;
    e.cyc = c; e.ch = ch; e.rise = rise;
    exp_q.push_back(e);
  endtask

  task automatic see_tick(input bit ch, input bit rise, input logic v);
    int idx;
    if (v === 1'b1) begin
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].ch == ch && exp_q[i].rise == rise)
          idx = i;
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL unexpected_tick ch=%0d rise=%0d at cycle %0d", ch, rise, cyc);
      end else begin
        exp_q.delete(idx);
      end
    end
  endtask

  // Scoreboard monitor: match ticks against the queue, flag missed ones.
  always @(negedge clk) begin
    if ((a_rise & a_fall) === 1'b1) chk("a_rise_and_fall", 1, 0);
    if ((b_rise & b_fall) === 1'b1) chk("b_rise_and_fall", 1, 0);
    see_tick(1'b0, 1'b1, a_rise);
    see_tick(1'b0, 1'b0, a_fall);
    see_tick(1'b1, 1'b1, b_rise);
    see_tick(1'b1, 1'b0, b_fall);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_tick ch=%0d rise=%0d: got none want cycle %0d", exp_q[i].ch, exp_q[i].rise, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k);
    int c0;
    int lvl;
    vec_t v;
    v = vecs[k];
    step();
    c0 = cyc;
    if (v.a_len > 0) a_raw = 1'b1;
    if (v.b_len > 0) b_raw = 1'b1;
    if (v.a_re > 0) push(c0 + v.a_re, 1'b0, 1'b1);
    if (v.a_fe > 0) push(c0 + v.a_fe, 1'b0, 1'b0);
    if (v.b_re > 0) push(c0 + v.b_re, 1'b1, 1'b1);
    if (v.b_fe > 0) push(c0 + v.b_fe, 1'b1, 1'b0);
    for (int t = 1; t <= 40; t++) begin
      step();
      if (t == v.a_len) a_raw = 1'b0;
      if (t == v.b_len) b_raw = 1'b0;
      if (t == 15) begin
        lvl = (v.a_re > 0 && v.a_re <= 15 && (v.a_fe == 0 || v.a_fe > 15)) ? 1 : 0;
        chk($sformatf("vec%0d_a_mid", k), int'(a), lvl);
        lvl = (v.b_re > 0 && v.b_re <= 15 && (v.b_fe == 0 || v.b_fe > 15)) ? 1 : 0;
        chk($sformatf("vec%0d_b_mid", k), int'(b), lvl);
      end
    end
    chk($sformatf("vec%0d_a_end", k), int'(a), 0);
    chk($sformatf("vec%0d_b_end", k), int'(b), 0);
  endtask

  initial begin
    int c0;
    bit lvl;

    // Expected edges worked out from an 8-sample count: rise 11 edges after
    // the raw change, fall len+11 edges after the start of an accepted pulse.
    vecs[0] = '{a_len: 8,  b_len: 0,  a_re: 0,  a_fe: 0,  b_re: 0,  b_fe: 0 };
    vecs[1] = '{a_len: 9,  b_len: 0,  a_re: 11, a_fe: 20, b_re: 0,  b_fe: 0 };
    vecs[2] = '{a_len: 0,  b_len: 9,  a_re: 0,  a_fe: 0,  b_re: 11, b_fe: 20};
    vecs[3] = '{a_len: 12, b_len: 12, a_re: 11, a_fe: 23, b_re: 11, b_fe: 23};
    vecs[4] = '{a_len: 3,  b_len: 15, a_re: 0,  a_fe: 0,  b_re: 11, b_fe: 26};
    vecs[5] = '{a_len: 1,  b_len: 8,  a_re: 0,  a_fe: 0,  b_re: 0,  b_fe: 0 };
    vecs[6] = '{a_len: 20, b_len: 8,  a_re: 11, a_fe: 31, b_re: 0,  b_fe: 0 };

    // Reset then idle.
    for (int t = 0; t < 3; t++) begin
      step();
      chk("rst_a", int'(a), 0);
      chk("rst_ticks", int'({a_rise, a_fall, b_rise, b_fall}), 0);
    end
    chk("rst_b", int'(b), 0);
    reset = 1'b1;
    for (int t = 0; t < 20; t++) step();
    chk("idle_a", int'(a), 0);
    chk("idle_b", int'(b), 0);

    // Table-driven pulses (thresholds, simultaneous channels, rejections).
    for (int k = 0; k < 7; k++) run_vec(k);

    // Clean press on A, held.
    step();
    c0 = cyc;
    a_raw = 1'b1;
    push(c0 + 11, 1'b0, 1'b1);
    for (int t = 1; t <= 14; t++) begin
      step();
      if (t == 10) chk("press_a_before", int'(a), 0);
      if (t == 11) chk("press_a_at", int'(a), 1);
    end
    chk("press_b", int'(b), 0);

    // Bounce while A is high: toggle every 3 cycles for 30 cycles, settle 0.
    step();
    c0 = cyc;
    lvl = 1'b0;
    a_raw = lvl;
    for (int t = 1; t <= 30; t++) begin
      step();
      if (t % 3 == 0) begin
        lvl = (t == 30) ? 1'b0 : ~lvl;
        a_raw = lvl;
      end
      chk("bounce_a_held", int'(a), 1);
    end
    push(c0 + 41, 1'b0, 1'b0);
    for (int t = 31; t <= 45; t++) begin
      step();
      if (t == 40) chk("bounce_a_before_fall", int'(a), 1);
      if (t == 41) chk("bounce_a_after_fall", int'(a), 0);
    end

    // Reset mid-operation with A high; raw stays high through release.
    step();
    c0 = cyc;
    a_raw = 1'b1;
    push(c0 + 11, 1'b0, 1'b1);
    for (int t = 1; t <= 13; t++) step();
    chk("prerst_a", int'(a), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_a_now", int'(a), 0);
    chk("midrst_ticks", int'({a_rise, a_fall}), 0);
    step();
    step();
    reset = 1'b1;
    c0 = cyc;
    push(c0 + 11, 1'b0, 1'b1);
    for (int t = 1; t <= 12; t++) begin
      step();
      if (t == 10) chk("postrst_a_before", int'(a), 0);
      if (t == 11) chk("postrst_a_at", int'(a), 1);
    end
    c0 = cyc;
    a_raw = 1'b0;
    push(c0 + 11, 1'b0, 1'b0);
    for (int t = 1; t <= 15; t++) step();
    chk("final_a", int'(a), 0);
    chk("final_b", int'(b), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
